fp16_to_uint12_pipe: RTL
========================

FP16_TO_UINT12_PIPE -- requirements
Module: fp16_to_uint12_pipe

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the saturation event counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_data holds a valid fp16 word.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-006 The block SHALL have port in_data, input, 16 bits: IEEE binary16 {sign, exp[4:0], man[9:0]}.
REQ-007 The block SHALL have port out_valid, output, 1 bit: out_data and the out flags are valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the downstream accepts the output.
REQ-009 The block SHALL have port out_data, output, 12 bits: the unsigned integer result.
REQ-010 The block SHALL have ports out_sat, out_neg and out_nan, each output, 1 bit: per-result status flags aligned with out_data.
REQ-011 The block SHALL have port cnt_clr, input, 1 bit: synchronous clear of sat_count.
REQ-012 The block SHALL have port sat_count, output, CNT_W bits: the number of saturated results delivered.

Function
REQ-013 An input transfer SHALL occur when in_valid and in_ready are both high; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-014 The pipeline SHALL have two register stages: S1 registers the decode and classification, S2 registers the shifted result and flags; out_valid SHALL equal S2 valid.
REQ-015 Advance SHALL be defined as (!out_valid || out_ready); in_ready SHALL equal advance; when advance is high, S1 SHALL load from the input and S2 SHALL load from S1; when advance is low, both stages SHALL hold.
REQ-016 Latency SHALL be 2 cycles from input transfer to out_valid when not stalled; throughput SHALL be 1 word per cycle; no word SHALL be lost or duplicated under backpressure.
REQ-017 out_data and the flags SHALL remain stable while out_valid is high and out_ready is low.
REQ-018 Conversion SHALL truncate toward zero, with k = exp - 15; the arithmetic rules are REQ-019 to REQ-024.
REQ-019 If exp is 0 (zero or subnormal), the result SHALL be 0 with no flags set, regardless of sign.
REQ-020 If exp is 31 and man is nonzero (NaN), the result SHALL be 0 with out_nan set.
REQ-021 If exp is 31, man is 0 and sign is 0 (+inf), the result SHALL be 4095 with out_sat set.
REQ-022 If sign is 1 and the value is nonzero (including -inf), the result SHALL be 0 with out_neg set.
REQ-023 For a positive normal value with k < 0, the result SHALL be 0 with no flag set.
REQ-024 For a positive normal value with 0 <= k <= 11, the result SHALL be ((1024 + man) << k) >> 10, giving a maximum of 4094; for k >= 12, the result SHALL be 4095 with out_sat set.
REQ-025 At most one flag SHALL be set per result.
REQ-026 sat_count SHALL increment by 1 on each output transfer with out_sat high, and SHALL saturate at all-ones with no wrap.
REQ-027 cnt_clr SHALL force sat_count to 0 on the next edge, and SHALL take priority over a simultaneous increment.
REQ-028 cnt_clr SHALL have no effect on the data pipeline.

Reset
REQ-029 While rst_n is low, S1 valid, S2 valid, out_valid, out_data, out_sat, out_neg, out_nan and sat_count SHALL all be 0; assertion SHALL take effect immediately, without waiting for a clock edge.
REQ-030 While rst_n is low, in_ready SHALL be 1, since advance is high when out_valid is 0.
REQ-031 Words in flight at reset assertion SHALL be discarded.
REQ-032 After rst_n deasserts, the first input transfer SHALL occur no earlier than the first rising edge of clk.

Verification
REQ-033 With out_ready held at 1, inputs 0x3C00, 0x4000, 0x4200, 0x4D00 and 0x6BFF on consecutive cycles SHALL produce outputs 1, 2, 3, 20 and 4094, each 2 cycles after its input, with no flags set.
REQ-034 Inputs 0x7000, 0x7C00, 0x7E00, 0xC000, 0x8000 and 0x3BFF SHALL produce, in order: 4095 with out_sat, 4095 with out_sat, 0 with out_nan, 0 with out_neg, 0 with no flag, and 0 with no flag; sat_count SHALL read 2 afterwards.
REQ-035 A stream of 0x3C00, 0x4000 and 0x4200 with out_ready low for 3 cycles mid-stream SHALL produce outputs 1, 2 and 3 in order, with in_ready low while stalled and out_data stable while stalled.
REQ-036 Driving rst_n low with 2 words in flight SHALL force out_valid to 0 and sat_count to 0 immediately; after release, input 0x4000 SHALL produce 2 after 2 cycles.
REQ-037 Forcing sat_count to all-ones with repeated 0x7C00 inputs SHALL leave it at all-ones on further saturations; cnt_clr asserted in the same cycle as a saturated output transfer SHALL make sat_count read 0.

Source files
------------

// File: rtl/fp16_to_uint12_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fp16_to_uint12_pipe
//  Purpose  : Two-stage pipelined IEEE binary16 to 12-bit unsigned integer
//             converter (truncate toward zero) with saturate/negative/NaN
//             status flags and a saturating count of saturated results.
//  Revision : 1.0  initial release
// ============================================================================
module fp16_to_uint12_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [11:0]      out_data,
    output logic             out_sat,
    output logic             out_neg,
    output logic             out_nan,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] sat_count
);

    // Result class decided in S1; S2 turns it into data and flags.
    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_NAN  = 3'd1,
        CLS_NEG  = 3'd2,
        CLS_SAT  = 3'd3,
        CLS_NORM = 3'd4
    } cls_t;

    localparam logic [4:0]  EXP_MAX   = 5'd31;
    localparam logic [4:0]  EXP_BIAS  = 5'd15;
    localparam logic [4:0]  EXP_SATLO = 5'd27;   // k = 12 and above saturate
    localparam logic [11:0] RES_SAT   = 12'hFFF;

    logic             advance;

    logic             s1_valid_q;
    cls_t             s1_cls_q,  s1_cls_d;
    logic [10:0]      s1_sig_q,  s1_sig_d;
    logic [3:0]       s1_k_q,    s1_k_d;

    logic             s2_valid_q;
    logic [11:0]      s2_data_q, s2_data_d;
    logic             s2_sat_q,  s2_sat_d;
    logic             s2_neg_q,  s2_neg_d;
    logic             s2_nan_q,  s2_nan_d;

    logic [CNT_W-1:0] sat_count_q, sat_count_d;

    logic             in_sign;
    logic [4:0]       in_exp;
    logic [9:0]       in_man;

    // Both stages move together whenever the output slot is free or draining.
    assign advance  = !s2_valid_q || out_ready;
    assign in_ready = advance;

    assign in_sign = in_data[15];
    assign in_exp  = in_data[14:10];
    assign in_man  = in_data[9:0];

    // Classify the incoming word and extract significand and shift amount.
    always_comb begin
        s1_cls_d = CLS_ZERO;
        s1_sig_d = {1'b1, in_man};
        s1_k_d   = 4'd0;
        if (in_exp == 5'd0) begin
            s1_cls_d = CLS_ZERO;
        end else if (in_exp == EXP_MAX && in_man != 10'd0) begin
            s1_cls_d = CLS_NAN;
        end else if (in_sign) begin
            s1_cls_d = CLS_NEG;
        end else if (in_exp == EXP_MAX) begin
            s1_cls_d = CLS_SAT;
        end else if (in_exp < EXP_BIAS) begin
            s1_cls_d = CLS_ZERO;
        end else if (in_exp >= EXP_SATLO) begin
            s1_cls_d = CLS_SAT;
        end else begin
            s1_cls_d = CLS_NORM;
            // exp in 15..26: (exp - 15) equals (exp + 1) modulo 16, i.e. 0..11
            s1_k_d   = in_exp[3:0] + 4'd1;
        end
    end

    // Stage 1 register: decoded class, significand and shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_cls_q   <= CLS_ZERO;
            s1_sig_q   <= 11'd0;
            s1_k_q     <= 4'd0;
        end else if (advance) begin
            s1_valid_q <= in_valid;
            s1_cls_q   <= s1_cls_d;
            s1_sig_q   <= s1_sig_d;
            s1_k_q     <= s1_k_d;
        end
    end

    // Build the integer result and the single status flag from the class.
    always_comb begin
        s2_data_d = 12'd0;
        s2_sat_d  = 1'b0;
        s2_neg_d  = 1'b0;
        s2_nan_d  = 1'b0;
        case (s1_cls_q)
            CLS_NAN:  s2_nan_d = 1'b1;
            CLS_NEG:  s2_neg_d = 1'b1;
            CLS_SAT: begin
                s2_data_d = RES_SAT;
                s2_sat_d  = 1'b1;
            end
            CLS_NORM: s2_data_d = 12'(({11'd0, s1_sig_q} << s1_k_q) >> 10);
            default:  s2_data_d = 12'd0;
        endcase
    end

    // Stage 2 register: final result and flags, held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= 12'd0;
            s2_sat_q   <= 1'b0;
            s2_neg_q   <= 1'b0;
            s2_nan_q   <= 1'b0;
        end else if (advance) begin
            s2_valid_q <= s1_valid_q;
            s2_data_q  <= s2_data_d;
            s2_sat_q   <= s2_sat_d;
            s2_neg_q   <= s2_neg_d;
            s2_nan_q   <= s2_nan_d;
        end
    end

    // Next saturation count: clear wins, otherwise count delivered saturations.
    always_comb begin
        sat_count_d = sat_count_q;
        if (cnt_clr) begin
            sat_count_d = '0;
        end else if (s2_valid_q && out_ready && s2_sat_q && !(&sat_count_q)) begin
            sat_count_d = sat_count_q + 1'b1;
        end
    end

    // Saturation event counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count_q <= '0;
        end else begin
            sat_count_q <= sat_count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_sat   = s2_sat_q;
    assign out_neg   = s2_neg_q;
    assign out_nan   = s2_nan_q;
    assign sat_count = sat_count_q;

endmodule
`default_nettype wire
